// File: rtl/copper_bar_scheduler.sv
// copper_bar_scheduler: on each vertical-blank entry, advances the animation
// frame and recomputes every copper-bar Y position from a shared wave-table
// port (one lookup per cycle). The results are double-buffered and committed
// only when a complete set is ready.
// Build option: define COPPER_SCHED_OVERRUN_EN to count aborted updates on
// out_overruns; otherwise out_overruns is tied to zero.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a vblank rise; host config writes accepted here
// ADVANCE | snapshot config, compute shadow frame and first table address
// LOOKUP  | N+1 pipelined cycles: issue addresses, capture returned samples
// COMMIT  | new position set and frame visible, out_done pulses
module copper_bar_scheduler #(
  parameter int NUM_BARS   = 4,
  parameter int BASE_Y_RST = 113,
  parameter int PHASE_RST  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_pix_vblank,
  input  logic                  in_cfg_valid,
  output logic                  out_cfg_ready,
  input  logic [1:0]            in_cfg_addr,
  input  logic [8:0]            in_cfg_data,
  output logic [5:0]            out_wave_addr,
  input  logic [6:0]            in_wave_data,
  output logic [9*NUM_BARS-1:0] out_bar_pos,
  output logic [5:0]            out_frame,
  output logic                  out_busy,
  output logic                  out_done,
  output logic [7:0]            out_overruns
);

  localparam int KW = $clog2(NUM_BARS + 1);

  typedef enum logic [1:0] {IDLE, ADVANCE, LOOKUP, COMMIT} state_t;

  state_t state, state_next;

  logic                  vblank_q;
  logic                  rise;
  logic                  abort;
  logic                  commit_go;
  logic                  last_lookup;
  logic [2:0]            cfg_speed;
  logic [5:0]            cfg_phase;
  logic [8:0]            cfg_base;
  logic                  cfg_enable;
  logic [5:0]            snap_phase;
  logic [8:0]            snap_base;
  logic [5:0]            shadow_frame;
  logic [5:0]            addr_acc;
  logic [KW-1:0]         lk_cnt;
  logic [8:0]            shadow [NUM_BARS];
  logic [8:0]            new_pos;
  logic [9*NUM_BARS-1:0] commit_vec;

  assign rise        = in_pix_vblank & ~vblank_q;
  assign last_lookup = (lk_cnt == KW'(NUM_BARS));
  assign new_pos     = snap_base + {1'b0, in_wave_data, 1'b0};

  // Commit set: the last bar's sample arrives on the same cycle as the commit,
  // so it is taken straight from the table rather than from the shadow buffer.
  always_comb begin
    commit_vec = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      commit_vec[9*i +: 9] = (i == NUM_BARS - 1) ? new_pos : shadow[i];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode; vblank dropping mid-update aborts.
  always_comb begin
    state_next    = state;
    out_cfg_ready = 1'b0;
    out_busy      = 1'b1;
    out_done      = 1'b0;
    abort         = 1'b0;
    commit_go     = 1'b0;
    out_wave_addr = 6'd0;
    case (state)
      IDLE: begin
        out_busy      = 1'b0;
        out_cfg_ready = 1'b1;
        if (rise && cfg_enable) state_next = ADVANCE;
      end
      ADVANCE: begin
        abort      = ~in_pix_vblank;
        state_next = abort ? IDLE : LOOKUP;
      end
      LOOKUP: begin
        if (!last_lookup) out_wave_addr = addr_acc;
        abort = ~in_pix_vblank;
        if (abort) begin
          state_next = IDLE;
        end else if (last_lookup) begin
          commit_go  = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        out_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Config staging, snapshot, lookup pipeline and double-buffered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vblank_q     <= 1'b0;
      cfg_speed    <= 3'd1;
      cfg_phase    <= 6'(PHASE_RST);
      cfg_base     <= 9'(BASE_Y_RST);
      cfg_enable   <= 1'b1;
      snap_phase   <= '0;
      snap_base    <= '0;
      shadow_frame <= '0;
      addr_acc     <= '0;
      lk_cnt       <= '0;
      out_bar_pos  <= '0;
      out_frame    <= '0;
      for (int i = 0; i < NUM_BARS; i++) shadow[i] <= '0;
    end else begin
      vblank_q <= in_pix_vblank;
      if (in_cfg_valid && out_cfg_ready) begin
        case (in_cfg_addr)
          2'd0:    cfg_speed  <= in_cfg_data[2:0];
          2'd1:    cfg_phase  <= in_cfg_data[5:0];
          2'd2:    cfg_base   <= in_cfg_data;
          default: cfg_enable <= in_cfg_data[0];
        endcase
      end
      if (state == ADVANCE) begin
        snap_phase   <= cfg_phase;
        snap_base    <= cfg_base;
        shadow_frame <= out_frame + {3'd0, cfg_speed};
        addr_acc     <= out_frame + {3'd0, cfg_speed};
        lk_cnt       <= '0;
      end
      if (state == LOOKUP) begin
        addr_acc <= addr_acc + snap_phase;
        lk_cnt   <= lk_cnt + 1'b1;
        for (int i = 0; i < NUM_BARS; i++) begin
          if (lk_cnt == KW'(i + 1)) shadow[i] <= new_pos;
        end
      end
      if (commit_go) begin
        out_bar_pos <= commit_vec;
        out_frame   <= shadow_frame;
      end
    end
  end

`ifdef COPPER_SCHED_OVERRUN_EN
  logic [7:0] overrun_cnt;

  // Saturating count of aborted updates; cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset)                             overrun_cnt <= 8'd0;
    else if (abort && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end

  assign out_overruns = overrun_cnt;
`else
  assign out_overruns = 8'd0;
`endif

endmodule

// File: doc/copper_bar_scheduler.md
# copper_bar_scheduler

Per-frame sequencer for the copper-bar display datapath. On every vertical-blank entry it advances the animation frame counter and computes all bar Y positions from one shared 64-entry wave-table port, one lookup per cycle. It double-buffers the results so the pixel datapath only sees a complete new position set, committed inside vblank. A small host config port sets speed, phase spacing, base Y and enable.

## Interface

Parameters:
- NUM_BARS, 4: number of bars scheduled (1..16).
- BASE_Y_RST, 113: reset value of base Y.
- PHASE_RST, 8: reset value of the per-bar phase step.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- in_pix_vblank  in  1  vertical blank from the VGA timing generator
- in_cfg_valid  in  1  config write request
- out_cfg_ready  out  1  config write accepted when valid && ready
- in_cfg_addr  in  2  0=speed[2:0], 1=phase[5:0], 2=base_y[8:0], 3=enable[0]
- in_cfg_data  in  9  write data, LSB-aligned; unused bits ignored
- out_wave_addr  out  6  wave-table address
- in_wave_data  in  7  wave-table data, valid one cycle after address
- out_bar_pos  out  9*NUM_BARS  active positions, bar i at [9i+8:9i], unsigned
- out_frame  out  6  committed frame counter
- out_busy  out  1  FSM not in IDLE
- out_done  out  1  one-cycle pulse on commit
- out_overruns  out  8  aborted-update count (see Configuration)

## Operation

- Vblank edge detect: vblank_q registered. rise = in_pix_vblank && !vblank_q.
- States:
  - IDLE: on rise && enable, go to ADVANCE. A rise with enable=0 is ignored.
  - ADVANCE: snapshot the config regs; shadow_frame = frame + speed (mod 64).
  - LOOKUP: N+1 cycles, pipelined.
    - Cycle k (0..N-1): out_wave_addr = (shadow_frame + k*phase) & 63.
    - Cycle k (1..N): shadow[k-1] = (base_y + (in_wave_data << 1)) mod 512.
  - COMMIT: active positions <= shadow, frame <= shadow_frame, out_done=1. Next state IDLE.
- Abort: if in_pix_vblank==0 in any cycle of ADVANCE or LOOKUP:
  - Go to IDLE next cycle.
  - Active positions and frame unchanged; shadow discarded; no done.
  - Overrun counter increments.
- Config:
  - out_cfg_ready = 1 only in IDLE.
  - Accepted writes update staging regs immediately and take effect at the next ADVANCE.
  - A write accepted in the same cycle as a rise is applied to that update.
- Arithmetic:
  - Positions are 9-bit unsigned, wrapping mod 512.
  - frame wraps mod 64.
  - k*phase is truncated to 6 bits.
- out_wave_addr is 0 outside LOOKUP.

## Timing

- Reset (reset==0 at a clock edge), applied on the next edge:
  - Outputs: all positions 0, out_frame=0, out_busy=0, out_done=0, out_overruns=0, out_wave_addr=0, out_cfg_ready=1.
  - Config regs: speed=1, phase=PHASE_RST, base_y=BASE_Y_RST, enable=1.
  - vblank_q=0, state IDLE.
- Reset mid-update returns to the reset values; no partial commit.
- If vblank is high when reset releases, a rise is detected on the first cycle out of reset.
- Rise sampled at cycle T:
  - T+1: ADVANCE.
  - T+2..T+2+N: LOOKUP.
  - T+3+N: COMMIT. New positions, frame and out_done are all visible after that edge.
- Total update latency is N+3 cycles. vblank must last at least N+3 cycles or the update aborts.
- Positions never change outside COMMIT or reset.

## Configuration

- COPPER_SCHED_OVERRUN_EN:
  - Defined: 8-bit saturating abort counter drives out_overruns. It clears only on reset.
  - Undefined: no counter logic; out_overruns tied to 0.
- Abort behaviour is identical with and without the macro.

## Test plan

- Defaults, NUM_BARS=4, bench wave model is the team's 64-entry half-sine (wave[1]=0, [3]=2, [9]=23, [17]=71, [25]=114). Reset, then one 40-cycle vblank:
  - out_done pulses at rise+7.
  - out_frame=1.
  - Positions = 113, 159, 255, 341.
- Write speed=3 in IDLE, then vblank:
  - out_frame=3.
  - bar0 = 113 + 2*wave[3] = 117.
- Write base_y=500 with phase giving wave=23 for bar 0:
  - bar0 = 546 mod 512 = 34.
- 4-cycle vblank pulse:
  - No done; positions and frame unchanged.
  - out_overruns=1 with macro defined, 0 without.
- Hold in_cfg_valid during an update:
  - out_cfg_ready=0 until IDLE.
  - Exactly one acceptance, on the cycle after COMMIT.
- Set enable=0, then vblank: no busy, no done. Also: reset asserted during LOOKUP leaves all outputs at reset values on the next cycle.
